// File: rtl/ball_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball subsystem: the direction-control state
// encoding and the screen geometry used by the ball position, paddle, brick
// and direction-control blocks.
//
// Geometry constants are 11 bits wide so that coordinate sums such as
// y + BALL_SIZE can be formed without wrapping a 10-bit pixel coordinate.
// ---------------------------------------------------------------------------
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DECIDE = 3'd2,
    MOVE   = 3'd3,
    LOST   = 3'd4
  } state_e;

  // Pixel coordinates as delivered by the position counters.
  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Coordinates widened by one bit for overflow-free sums and compares.
  typedef logic [COORD_W:0] coord_ext_t;

  localparam coord_ext_t X_MAX     = 11'd639; // rightmost pixel column
  localparam coord_ext_t Y_MAX     = 11'd479; // bottom pixel row
  localparam coord_ext_t BALL_SIZE = 11'd4;   // ball edge length
  localparam coord_ext_t PADDLE_Y  = 11'd460; // top row of the paddle
  localparam coord_ext_t PADDLE_W  = 11'd40;  // paddle width

  // Zero-extend a pixel coordinate into the wide arithmetic domain.
  function automatic coord_ext_t ext(input coord_t v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/step_tick.sv
// ---------------------------------------------------------------------------
// step_tick
// Free-running divider that paces ball steps. Counts 0..TICK_DIV-1 while
// enabled and wraps to 0 on the terminal count, which it flags with a
// one-cycle pulse. A synchronous clear forces the count back to 0.
//
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous, active-high
//   en_i    in  count enable
//   clr_i   in  synchronous clear (takes priority over en_i)
//   tick_o  out terminal-count pulse, high while enabled at TICK_DIV-1
// ---------------------------------------------------------------------------
module step_tick #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TERM);

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_dir_ctrl.sv
// ---------------------------------------------------------------------------
// ball_dir_ctrl
// Ball direction controller. Paces ball steps, decides reflections off the
// walls, paddle and bricks once per step, emits the move enable and the
// direction bits consumed by the position counters, and flags a lost ball.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   start        in   one-cycle pulse; launches the ball from IDLE
//   x, y         in   current ball left column / top row
//   paddle_x     in   paddle left column
//   brick_hit_x  in   pulse: brick struck on a vertical face
//   brick_hit_y  in   pulse: brick struck on a horizontal face
//   move_en      out  one-cycle pulse; position counters step once
//   x_du         out  x direction (1 = right / increment)
//   y_du         out  y direction (1 = down / increment)
//   lost         out  one-cycle pulse; ball passed the paddle
//   running      out  high while in RUN, DECIDE or MOVE
// ---------------------------------------------------------------------------
module ball_dir_ctrl
  import ball_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic [9:0]   paddle_x,
  input  logic         brick_hit_x,
  input  logic         brick_hit_y,
  output logic         move_en,
  output logic         x_du,
  output logic         y_du,
  output logic         lost,
  output logic         running
);

  state_e state_q, state_d;
  logic   x_du_q, x_du_d;
  logic   y_du_q, y_du_d;
  logic   brick_x_q, brick_x_d;
  logic   brick_y_q, brick_y_d;
  logic   move_en_q, lost_q, running_q;
  logic   tick;

  // -------------------------------------------------------------------------
  // Step pacing: counts only in RUN; the launch from IDLE restarts the count.
  // -------------------------------------------------------------------------
  step_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_step_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == RUN),
    .clr_i  ((state_q == IDLE) && start),
    .tick_o (tick)
  );

  // -------------------------------------------------------------------------
  // Geometry tests, all in 11-bit arithmetic.
  // -------------------------------------------------------------------------
  coord_ext_t x_e, y_e, px_e, x_far, y_far;

  assign x_e   = ext(x);
  assign y_e   = ext(y);
  assign px_e  = ext(paddle_x);
  assign x_far = x_e + BALL_SIZE;
  assign y_far = y_e + BALL_SIZE;

  logic hit_bottom, hit_paddle, hit_top, hit_right, hit_left;

  assign hit_bottom = y_du_q && (y_far >= Y_MAX);
  // Ball bottom edge sits exactly on the paddle top and the spans overlap.
  assign hit_paddle = y_du_q && (y_far == PADDLE_Y) &&
                      (x_far > px_e) && (x_e < px_e + PADDLE_W);
  assign hit_top    = !y_du_q && (y_e == '0);
  assign hit_right  = x_du_q && (x_far >= X_MAX);
  assign hit_left   = !x_du_q && (x_e == '0);

  // -------------------------------------------------------------------------
  // State machine and direction update.
  // -------------------------------------------------------------------------
  logic x_refl, y_refl;

  always_comb begin
    state_d = state_q;
    x_du_d  = x_du_q;
    y_du_d  = y_du_q;
    x_refl  = 1'b0;
    y_refl  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_du_d  = 1'b1;
          y_du_d  = 1'b0;
        end
      end

      RUN: begin
        if (tick) state_d = DECIDE;
      end

      DECIDE: begin
        if (hit_bottom) begin
          state_d = LOST;
        end else begin
          state_d = MOVE;

          if (hit_paddle) begin
            y_du_d = 1'b0;
            y_refl = 1'b1;
          end else if (hit_top) begin
            y_du_d = 1'b1;
            y_refl = 1'b1;
          end

          if (hit_right) begin
            x_du_d = 1'b0;
            x_refl = 1'b1;
          end else if (hit_left) begin
            x_du_d = 1'b1;
            x_refl = 1'b1;
          end

          // A brick only flips an axis that a wall or the paddle has not
          // already reflected, so each axis turns at most once per step.
          if (brick_x_q && !x_refl) x_du_d = !x_du_q;
          if (brick_y_q && !y_refl) y_du_d = !y_du_q;
        end
      end

      MOVE:    state_d = RUN;
      LOST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sticky brick flags: captured while the ball is in play, consumed on
  // DECIDE exit, dropped in LOST. A strobe coincident with the clear wins.
  // -------------------------------------------------------------------------
  logic brick_accept, brick_clear;

  assign brick_accept = (state_q == RUN) || (state_q == DECIDE) || (state_q == MOVE);
  assign brick_clear  = (state_q == DECIDE) || (state_q == LOST);

  always_comb begin
    brick_x_d = (brick_accept && brick_hit_x) || (brick_x_q && !brick_clear);
    brick_y_d = (brick_accept && brick_hit_y) || (brick_y_q && !brick_clear);
  end

  // -------------------------------------------------------------------------
  // Registers. Output strobes are registered from the next state so they
  // coincide exactly with the MOVE / LOST cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_du_q    <= 1'b1;
      y_du_q    <= 1'b0;
      brick_x_q <= 1'b0;
      brick_y_q <= 1'b0;
      move_en_q <= 1'b0;
      lost_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_du_q    <= x_du_d;
      y_du_q    <= y_du_d;
      brick_x_q <= brick_x_d;
      brick_y_q <= brick_y_d;
      move_en_q <= (state_d == MOVE);
      lost_q    <= (state_d == LOST);
      running_q <= (state_d == RUN) || (state_d == DECIDE) || (state_d == MOVE);
    end
  end

  assign move_en = move_en_q;
  assign lost    = lost_q;
  assign running = running_q;
  assign x_du    = x_du_q;
  assign y_du    = y_du_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_dir_ctrl
// Directed bench for ball_dir_ctrl with TICK_DIV = 4, giving a step every
// 6 cycles (4 in RUN, 1 DECIDE, 1 MOVE). The bench plays the role of the
// position counters by driving x/y directly before each step.
// ---------------------------------------------------------------------------
module tb_ball_dir_ctrl;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x, y, paddle_x;
  logic       brick_hit_x, brick_hit_y;
  logic       move_en, x_du, y_du, lost, running;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ball_dir_ctrl #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x           (x),
    .y           (y),
    .paddle_x    (paddle_x),
    .brick_hit_x (brick_hit_x),
    .brick_hit_y (brick_hit_y),
    .move_en     (move_en),
    .x_du        (x_du),
    .y_du        (y_du),
    .lost        (lost),
    .running     (running)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n cycles; no strobe may appear before the last one.
  task automatic advance(input int n, input string tag);
    for (int i = 1; i < n; i++) begin
      step();
      check($sformatf("%s quiet c%0d", tag, i), move_en | lost, 1'b0);
    end
    step();
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    x           = 10'd100;
    y           = 10'd200;
    paddle_x    = 10'd300;
    brick_hit_x = 1'b0;
    brick_hit_y = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst move_en", move_en, 1'b0);
    check("rst lost",    lost,    1'b0);
    check("rst running", running, 1'b0);
    check("rst x_du",    x_du,    1'b1);
    check("rst y_du",    y_du,    1'b0);
    reset = 1'b0;
    step();
    check("idle running", running, 1'b0);

    // Launch
    start = 1'b1;
    step();
    start = 1'b0;
    check("launch running", running, 1'b1);
    check("launch move_en", move_en, 1'b0);
    advance(5, "launch");
    check("launch step move_en", move_en, 1'b1);
    check("launch step x_du",    x_du,    1'b1);
    check("launch step y_du",    y_du,    1'b0);
    check("launch step lost",    lost,    1'b0);
    check("launch step running", running, 1'b1);
    advance(6, "cadence");
    check("cadence move_en", move_en, 1'b1);
    check("cadence x_du",    x_du,    1'b1);
    check("cadence y_du",    y_du,    1'b0);

    // Right wall: 635 + 4 >= 639
    x = 10'd635;
    advance(6, "rwall");
    check("rwall move_en", move_en, 1'b1);
    check("rwall x_du",    x_du,    1'b0);
    check("rwall y_du",    y_du,    1'b0);
    x = 10'd300;

    // Top wall
    y = 10'd0;
    advance(6, "top");
    check("top move_en", move_en, 1'b1);
    check("top y_du",    y_du,    1'b1);
    check("top x_du",    x_du,    1'b0);
    y = 10'd200;

    // Brick on horizontal face, strobed in RUN
    step();
    brick_hit_y = 1'b1;
    step();
    brick_hit_y = 1'b0;
    advance(4, "bricky");
    check("bricky move_en", move_en, 1'b1);
    check("bricky y_du",    y_du,    1'b0);
    check("bricky x_du",    x_du,    1'b0);

    // Following step unaffected; start in RUN is ignored
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    advance(4, "after bricky");
    check("after bricky move_en", move_en, 1'b1);
    check("after bricky y_du",    y_du,    1'b0);
    check("start ignored x_du",   x_du,    1'b0);

    // Brick on vertical face coinciding with the left wall
    x = 10'd0;
    step();
    brick_hit_x = 1'b1;
    step();
    brick_hit_x = 1'b0;
    advance(4, "bwall");
    check("bwall move_en", move_en, 1'b1);
    check("bwall x_du",    x_du,    1'b1);
    check("bwall y_du",    y_du,    1'b0);
    x = 10'd300;
    advance(6, "after bwall");
    check("after bwall move_en", move_en, 1'b1);
    check("after bwall x_du",    x_du,    1'b1);

    // Paddle hit: 456 + 4 == 460, 104 > 90, 100 < 130
    y = 10'd0;
    advance(6, "prep1");
    check("prep1 y_du", y_du, 1'b1);
    y        = 10'd456;
    paddle_x = 10'd90;
    x        = 10'd100;
    advance(6, "paddle");
    check("paddle move_en", move_en, 1'b1);
    check("paddle y_du",    y_du,    1'b0);
    check("paddle x_du",    x_du,    1'b1);
    check("paddle lost",    lost,    1'b0);

    // Paddle miss: 475 + 4 >= 479
    y = 10'd0;
    advance(6, "prep2");
    check("prep2 y_du", y_du, 1'b1);
    paddle_x = 10'd300;
    y        = 10'd475;
    advance(6, "miss");
    check("miss lost",    lost,    1'b1);
    check("miss move_en", move_en, 1'b0);
    check("miss running", running, 1'b0);
    check("miss x_du",    x_du,    1'b1);
    check("miss y_du",    y_du,    1'b1);
    step();
    check("post lost lost",    lost,    1'b0);
    check("post lost running", running, 1'b0);
    advance(8, "idle");
    check("idle move_en",     move_en, 1'b0);
    check("idle running end", running, 1'b0);

    // Relaunch, then reset during the move_en cycle
    x     = 10'd635;
    y     = 10'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    check("relaunch running", running, 1'b1);
    check("relaunch x_du",    x_du,    1'b1);
    check("relaunch y_du",    y_du,    1'b0);
    advance(5, "relaunch");
    check("relaunch move_en", move_en, 1'b1);
    check("relaunch step x_du", x_du,  1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst move_en", move_en, 1'b0);
    check("midrst x_du",    x_du,    1'b1);
    check("midrst y_du",    y_du,    1'b0);
    check("midrst running", running, 1'b0);
    check("midrst lost",    lost,    1'b0);
    step();
    reset = 1'b0;
    advance(10, "post reset");
    check("post reset move_en", move_en, 1'b0);
    check("post reset running", running, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume running", running, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_dir_ctrl.md
Name: ball_dir_ctrl

Overview:
- Drives the ball position counters: generates the per-step move enable and the x/y direction bits (1 = increment, 0 = decrement) that the position counters consume.
- Reads back the current ball x/y, paddle position and brick-collision strobes.
- Reflects the ball off walls, paddle and bricks, and flags a lost ball at the bottom edge.
- Sits between the game-control FSM and the ball position block.

Parameters:
- X_MAX, 639, rightmost pixel column.
- Y_MAX, 479, bottom pixel row.
- BALL_SIZE, 4, ball edge length in pixels.
- PADDLE_Y, 460, top row of the paddle.
- PADDLE_W, 40, paddle width in pixels.
- TICK_DIV, 500000, clk cycles per ball step (≥3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; launches ball from IDLE.
- x  in  10  current ball left column, from position counter.
- y  in  10  current ball top row, from position counter.
- paddle_x  in  10  paddle left column.
- brick_hit_x  in  1  pulse: brick struck on a vertical face.
- brick_hit_y  in  1  pulse: brick struck on a horizontal face.
- move_en  out  1  one-cycle pulse; position counters step once.
- x_du  out  1  x direction (1 = right/increment).
- y_du  out  1  y direction (1 = down/increment).
- lost  out  1  one-cycle pulse; ball passed the paddle.
- running  out  1  high while state is RUN, DECIDE or MOVE.

Behaviour:
- Reset values:
  - state IDLE.
  - x_du=1, y_du=0.
  - move_en=0, lost=0, running=0.
  - tick counter 0; brick flags 0.
- States: IDLE, RUN, DECIDE, MOVE, LOST.
- IDLE:
  - start → RUN.
  - On that transition x_du←1, y_du←0 and the tick counter is cleared.
- RUN:
  - Tick counter counts 0..TICK_DIV-1, counting only in RUN.
  - At terminal count → DECIDE, counter ←0.
  - start is ignored outside IDLE.
- DECIDE (one cycle): evaluate x, y and direction bits, using 11-bit arithmetic for all sums (no 10-bit wrap). Priority:
  1. y_du=1 and y+BALL_SIZE ≥ Y_MAX → LOST; directions unchanged; no move_en.
  2. Paddle bounce: y_du=1, y+BALL_SIZE == PADDLE_Y, x+BALL_SIZE > paddle_x and x < paddle_x+PADDLE_W → y_du←0.
  3. Top wall: y_du=0 and y==0 → y_du←1.
  4. Horizontal walls: x_du=1 and x+BALL_SIZE ≥ X_MAX → x_du←0; x_du=0 and x==0 → x_du←1.
  5. Brick flags: toggle the corresponding direction bit if set, but only on an axis not already reflected this DECIDE.
  - Then → MOVE. Both brick flags clear on DECIDE exit.
- Brick flags:
  - Sticky; set by strobes in RUN, DECIDE or MOVE.
  - A strobe arriving in the same cycle as the clear is kept (set wins).
- MOVE: move_en=1 for exactly this cycle; → RUN.
  - Direction bits are stable from DECIDE exit through MOVE, so the counters sample final values.
  - New x/y are visible the cycle after MOVE.
  - Step latency: terminal count → move_en high = 2 cycles.
- LOST: lost=1 for exactly this cycle; → IDLE; brick flags cleared.
- running: registered; equals (state ∈ {RUN, DECIDE, MOVE}).
- Reset asserted mid-operation: immediate asynchronous return to reset values; any in-flight move_en or lost is dropped.
- Wall and paddle conditions on the same axis in the same DECIDE are resolved by the priority order above, so exactly one reflection per axis per step.

Decomposition:
- Shared package ball_pkg:
  - state enum (IDLE, RUN, DECIDE, MOVE, LOST).
  - Screen constants X_MAX, Y_MAX, BALL_SIZE, PADDLE_Y, PADDLE_W, also used by ball position, paddle and brick blocks.
- One sub-module, step_tick:
  - Parameterised TICK_DIV counter with enable and synchronous clear.
  - Outputs a one-cycle terminal-count pulse.

Test Plan:
- Launch: TICK_DIV=4, reset, start pulse, x=100, y=200 → running=1 next cycle; move_en pulses every 6 cycles with x_du=1, y_du=0; lost stays 0.
- Right wall: x=635, x_du=1, tick → in DECIDE x_du←0; move_en sees x_du=0; y_du unchanged.
- Paddle hit vs miss:
  - y=456, y_du=1, paddle_x=90, x=100 → y_du←0, move_en pulses.
  - Same with paddle_x=300 and y=475 → lost pulse, no move_en, state IDLE, running=0.
- Brick strobe: brick_hit_y pulsed in RUN with y_du=1, y=200 → next DECIDE y_du←0; flag cleared; following step unaffected.
- Brick and wall on the same axis: x=0, x_du=0, brick_hit_x set → x_du=1 exactly once, not toggled back to 0.
- Reset mid-MOVE: assert reset during the move_en cycle → move_en drops immediately; outputs at reset values; start required to resume.
